// File: rtl/tb_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the bench memory model.
// One access in flight at a time; completion is an ack pulse, or err on timeout.
module tb_mem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_sz,
  input  logic              p0_we,
  input  logic [7:0]        p0_wdata_8,
  input  logic [15:0]       p0_wdata_16,
  output logic              p0_ack,
  output logic [7:0]        p0_rdata_8,
  output logic [15:0]       p0_rdata_16,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_sz,
  input  logic              p1_we,
  input  logic [7:0]        p1_wdata_8,
  input  logic [15:0]       p1_wdata_16,
  output logic              p1_ack,
  output logic [7:0]        p1_rdata_8,
  output logic [15:0]       p1_rdata_16,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_sz,
  output logic              mem_we_8,
  output logic              mem_we_16,
  output logic [7:0]        mem_wdata_8,
  output logic [15:0]       mem_wdata_16,
  input  logic [7:0]        mem_rdata_8,
  input  logic [15:0]       mem_rdata_16,
  input  logic              mem_data_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_port;
  logic        r_we;
  logic [7:0]  r_cnt;

  logic              w_pick;
  logic [ADDR_W-1:0] w_addr;
  logic              w_sz;
  logic              w_we;
  logic [7:0]        w_wd8;
  logic [15:0]       w_wd16;

  // On a tie the port that did not win last time goes; otherwise whoever asks.
  assign w_pick = (p0_req && p1_req) ? ~r_last : p1_req;
  assign w_addr = w_pick ? p1_addr     : p0_addr;
  assign w_sz   = w_pick ? p1_sz       : p0_sz;
  assign w_we   = w_pick ? p1_we       : p0_we;
  assign w_wd8  = w_pick ? p1_wdata_8  : p0_wdata_8;
  assign w_wd16 = w_pick ? p1_wdata_16 : p0_wdata_16;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      err          <= 1'b0;
      p0_rdata_8   <= '0;
      p0_rdata_16  <= '0;
      p1_rdata_8   <= '0;
      p1_rdata_16  <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_sz       <= 1'b0;
      mem_we_8     <= 1'b0;
      mem_we_16    <= 1'b0;
      mem_wdata_8  <= '0;
      mem_wdata_16 <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      err    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (p0_req || p1_req) begin
            r_port       <= w_pick;
            r_last       <= w_pick;
            r_we         <= w_we;
            r_cnt        <= '0;
            mem_req      <= 1'b1;
            mem_addr     <= w_addr;
            mem_sz       <= w_sz;
            mem_we_8     <= w_we & ~w_sz;
            mem_we_16    <= w_we & w_sz;
            mem_wdata_8  <= w_wd8;
            mem_wdata_16 <= w_wd16;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_data_ready) begin
            if (!r_we) begin
              if (!mem_sz) begin
                if (r_port) p1_rdata_8 <= mem_rdata_8;
                else        p0_rdata_8 <= mem_rdata_8;
              end else begin
                if (r_port) p1_rdata_16 <= mem_rdata_16;
                else        p0_rdata_16 <= mem_rdata_16;
              end
            end
            if (r_port) p1_ack <= 1'b1;
            else        p0_ack <= 1'b1;
            mem_req   <= 1'b0;
            mem_we_8  <= 1'b0;
            mem_we_16 <= 1'b0;
            r_state   <= DONE;
          end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            mem_req   <= 1'b0;
            mem_we_8  <= 1'b0;
            mem_we_16 <= 1'b0;
            err       <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // Idle gap so the memory's data_ready can fall before the next grant.
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Randomized bench for tb_mem_arbiter: byte-array memory model plus a
// transaction-level reference (round-robin rule, byte memory, held rdata).
module tb_tb_mem_arbiter;
  localparam int AW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  q_req;
  logic [1:0]  q_sz;
  logic [1:0]  q_we;
  logic [AW-1:0] q_addr [2];
  logic [7:0]  q_w8 [2];
  logic [15:0] q_w16 [2];

  logic p0_ack, p1_ack, err, mem_req, mem_sz, mem_we_8, mem_we_16;
  logic [7:0]  p0_rdata_8, p1_rdata_8, mem_wdata_8;
  logic [15:0] p0_rdata_16, p1_rdata_16, mem_wdata_16;
  logic [AW-1:0] mem_addr;
  logic        mem_data_ready = 1'b0;
  logic [7:0]  mem_rdata_8 = '0;
  logic [15:0] mem_rdata_16 = '0;

  tb_mem_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .p0_req(q_req[0]), .p0_addr(q_addr[0]), .p0_sz(q_sz[0]), .p0_we(q_we[0]),
    .p0_wdata_8(q_w8[0]), .p0_wdata_16(q_w16[0]),
    .p0_ack(p0_ack), .p0_rdata_8(p0_rdata_8), .p0_rdata_16(p0_rdata_16),
    .p1_req(q_req[1]), .p1_addr(q_addr[1]), .p1_sz(q_sz[1]), .p1_we(q_we[1]),
    .p1_wdata_8(q_w8[1]), .p1_wdata_16(q_w16[1]),
    .p1_ack(p1_ack), .p1_rdata_8(p1_rdata_8), .p1_rdata_16(p1_rdata_16),
    .err(err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_sz(mem_sz),
    .mem_we_8(mem_we_8), .mem_we_16(mem_we_16),
    .mem_wdata_8(mem_wdata_8), .mem_wdata_16(mem_wdata_16),
    .mem_rdata_8(mem_rdata_8), .mem_rdata_16(mem_rdata_16),
    .mem_data_ready(mem_data_ready)
  );

  // Memory model: little-endian byte array, data_ready after 1 or 2 cycles of req.
  logic [7:0] mem [65536];
  logic       ready_en = 1'b1;
  int         m_cnt = 0, m_delay = 0, wr_cnt = 0;
  wire [AW-1:0] m_a1 = mem_addr + 16'd1;

  always @(posedge clk) begin
    if (reset || !mem_req) begin
      m_cnt          <= 0;
      m_delay        <= int'($urandom_range(1));
      mem_data_ready <= 1'b0;
    end else if (!mem_data_ready && ready_en) begin
      if (m_cnt >= m_delay) begin
        mem_data_ready <= 1'b1;
        mem_rdata_8    <= mem[mem_addr];
        mem_rdata_16   <= {mem[m_a1], mem[mem_addr]};
        if (mem_we_8) mem[mem_addr] <= mem_wdata_8;
        if (mem_we_16) begin
          mem[mem_addr] <= mem_wdata_16[7:0];
          mem[m_a1]     <= mem_wdata_16[15:8];
        end
        if (mem_we_8 || mem_we_16) wr_cnt <= wr_cnt + 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Reference state
  logic [7:0]  rmem [65536];
  logic [7:0]  ref_rd8 [2];
  logic [15:0] ref_rd16 [2];
  bit [1:0]    pend;
  int          req_n [2];
  int infl = -1, ref_last = 1, issue_cyc = 0, idle_from = 0, n = 0, last_ack_n = 0;
  logic [AW-1:0] f_addr;
  logic        f_sz, f_we;
  logic [7:0]  f_w8;
  logic [15:0] f_w16;
  logic        prev_req = 1'b0;
  bit          mon_on = 0, rnd = 0, mutate = 0, cont = 0;
  int          glog [$];
  int          n_ack = 0, n_errp = 0, n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic new_req(input int p, input logic [15:0] a, input logic sz, input logic we,
                         input logic [7:0] w8, input logic [15:0] w16);
    q_addr[p] = a; q_sz[p] = sz; q_we[p] = we; q_w8[p] = w8; q_w16[p] = w16;
    q_req[p] = 1'b1; pend[p] = 1'b1; req_n[p] = n;
  endtask

  task automatic rand_req(input int p);
    logic [15:0] a;
    a = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom_range(63));
    new_req(p, a, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom), 16'($urandom));
  endtask

  task automatic monitor();
    logic granted;
    int g;
    logic [AW-1:0] a1;
    granted = mem_req && !prev_req;
    chk("grant_when", granted, (n >= idle_from) && (q_req != 2'b00));
    if (granted) begin
      g = (q_req == 2'b11) ? 1 - ref_last : (q_req[1] ? 1 : 0);
      glog.push_back(g);
      f_addr = q_addr[g]; f_sz = q_sz[g]; f_we = q_we[g]; f_w8 = q_w8[g]; f_w16 = q_w16[g];
      infl = g; ref_last = g; issue_cyc = n; idle_from = 1 << 30;
    end
    if (mem_req) begin
      chk("mem_addr", mem_addr, f_addr);
      chk("mem_ctl", {mem_sz, mem_we_8, mem_we_16}, {f_sz, f_we & ~f_sz, f_we & f_sz});
      chk("mem_wdata", {mem_wdata_8, mem_wdata_16}, {f_w8, f_w16});
    end
    chk("spurious", (p0_ack || p1_ack || err) && (infl < 0), 0);
    chk("one_hot", {p0_ack, p1_ack, err} inside {3'b000, 3'b100, 3'b010, 3'b001}, 1);
    if ((p0_ack || p1_ack) && infl >= 0) begin
      chk("ack_port", p1_ack ? 1 : 0, infl);
      chk("ack_mreq", {mem_req, mem_we_8, mem_we_16}, 0);
      a1 = f_addr + 16'd1;
      if (f_we) begin
        if (f_sz) begin rmem[f_addr] = f_w16[7:0]; rmem[a1] = f_w16[15:8]; end
        else rmem[f_addr] = f_w8;
      end else if (f_sz) ref_rd16[infl] = {rmem[a1], rmem[f_addr]};
      else ref_rd8[infl] = rmem[f_addr];
      pend[infl] = 1'b0; q_req[infl] = 1'b0;
      infl = -1; idle_from = n + 2; n_ack++; last_ack_n = n;
    end else if (err && infl >= 0) begin
      chk("err_time", n - issue_cyc, TO);
      chk("err_mreq", mem_req, 0);
      infl = -1; idle_from = n + 2; n_errp++;
    end
    if (infl >= 0 && n - issue_cyc > TO + 1) begin
      chk("watchdog", n - issue_cyc, TO + 1);
      infl = -1; idle_from = n + 2;
    end
    chk("p0_rd8", p0_rdata_8, ref_rd8[0]);
    chk("p1_rd8", p1_rdata_8, ref_rd8[1]);
    chk("p0_rd16", p0_rdata_16, ref_rd16[0]);
    chk("p1_rd16", p1_rdata_16, ref_rd16[1]);
    prev_req = mem_req;
  endtask

  task automatic drive_rand();
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && (cont || $urandom_range(2) == 0)) rand_req(p);
      else if (mutate && infl == p && $urandom_range(3) == 0) begin
        q_req[p] = 1'($urandom_range(1)); q_addr[p] = 16'($urandom);
        q_we[p] = 1'($urandom_range(1)); q_w8[p] = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    if (mon_on) monitor(); else prev_req = mem_req;
    if (rnd) drive_rand();
  endtask

  task automatic clr_state();
    infl = -1; ref_last = 1; pend = '0; q_req = '0;
    for (int p = 0; p < 2; p++) begin ref_rd8[p] = '0; ref_rd16[p] = '0; end
    idle_from = n + 1; prev_req = mem_req;
  endtask

  task automatic do_reset();
    mon_on = 0; reset = 1'b1; q_req = '0; pend = '0;
    step(); step();
    chk("rst_ctl", {p0_ack, p1_ack, err, mem_req, mem_sz, mem_we_8, mem_we_16}, 0);
    chk("rst_mem", {mem_addr, mem_wdata_8}, 0);
    chk("rst_wd16", mem_wdata_16, 0);
    chk("rst_rd_a", {p0_rdata_16, p0_rdata_8}, 0);
    chk("rst_rd_b", {p1_rdata_16, p1_rdata_8}, 0);
    reset = 1'b0;
    clr_state();
    mon_on = 1;
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && (pend != 2'b00 || infl >= 0); i++) step();
    chk("drain", {pend, 1'(infl >= 0)}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end by itself");
    $fatal(1);
  end

  initial begin
    int a0, w0, e0, g0, lat;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; rmem[i] = '0; end
    mem[16'h0010] = 8'hA5; rmem[16'h0010] = 8'hA5;
    q_req = '0; q_sz = '0; q_we = '0;
    for (int p = 0; p < 2; p++) begin q_addr[p] = '0; q_w8[p] = '0; q_w16[p] = '0; end
    reset = 1'b1;

    // 8-bit read of preloaded byte
    do_reset();
    a0 = n_ack;
    new_req(0, 16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000);
    wait_done(30);
    lat = last_ack_n - req_n[0];
    chk("t1_rd8", p0_rdata_8, 8'hA5);
    chk("t1_ack", n_ack - a0, 1);
    chk("t1_lat", (lat == 3 || lat == 4), 1);

    // 16-bit write then read back on port 1
    w0 = wr_cnt;
    new_req(1, 16'h0200, 1'b1, 1'b1, 8'h00, 16'hBEEF);
    wait_done(30);
    new_req(1, 16'h0200, 1'b1, 1'b0, 8'h00, 16'h0000);
    wait_done(30);
    chk("t2_rd16", p1_rdata_16, 16'hBEEF);
    chk("t2_writes", wr_cnt - w0, 1);

    // both ports continuously from reset: strict alternation starting at port 0
    do_reset();
    glog.delete();
    cont = 1; rnd = 1;
    for (int i = 0; i < 200 && glog.size() < 8; i++) step();
    cont = 0; rnd = 0;
    wait_done(40);
    chk("t3_count", glog.size() >= 8, 1);
    chk("t3_first", glog[0], 0);
    for (int i = 1; i < 8; i++) chk("t3_alt", glog[i], 1 - glog[i-1]);

    // timeout abort, then port 1 and the retried port 0 complete
    ready_en = 1'b0; e0 = n_errp; a0 = n_ack;
    new_req(0, 16'h0030, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 20 && infl < 0; i++) step();
    new_req(1, 16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 40 && n_errp == e0; i++) step();
    ready_en = 1'b1;
    g0 = glog.size();
    wait_done(60);
    chk("t4_err", n_errp - e0, 1);
    chk("t4_acks", n_ack - a0, 2);
    chk("t4_next", glog[g0], 1);

    // reset one cycle into ISSUE
    new_req(0, 16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000);
    wait_done(30);
    chk("t5_pre", p0_rdata_8, 8'hA5);
    new_req(0, 16'h0010, 1'b1, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 20 && infl < 0; i++) step();
    chk("t5_gnt", infl, 0);
    mon_on = 0; reset = 1'b1;
    step();
    chk("t5_ctl", {mem_req, p0_ack, p1_ack, err}, 0);
    chk("t5_rd", {p0_rdata_16, p0_rdata_8}, 0);
    reset = 1'b0;
    clr_state();
    mon_on = 1;
    new_req(0, 16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000);
    wait_done(30);
    chk("t5_post", p0_rdata_8, 8'hA5);

    // port 0 drops and scrambles its request after grant; port 1 goes next
    a0 = n_ack;
    new_req(0, 16'h0011, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 20 && infl < 0; i++) step();
    step();
    q_req[0] = 1'b0; q_addr[0] = 16'h0777; q_sz[0] = 1'b1;
    new_req(1, 16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000);
    g0 = glog.size();
    wait_done(40);
    chk("t6_acks", n_ack - a0, 2);
    chk("t6_next", glog[g0], 1);
    chk("t6_rd", p1_rdata_8, 8'hA5);

    // randomized traffic, including 0xFFFF and input churn while in flight
    a0 = n_ack;
    rnd = 1; mutate = 1;
    for (int i = 0; i < 3000; i++) step();
    rnd = 0; mutate = 0;
    wait_done(60);
    chk("rand_acks", (n_ack - a0) > 300, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tb_mem_arbiter.md
Name: tb_mem_arbiter

Overview:
- Two-port request arbiter and sequencer sitting directly upstream of the test-bench memory model.
- Port 0 is the CPU data port; port 1 is the instruction-fetch port.
- Grants one requester at a time, drives the memory's single request/address/size/write-enable/write-data interface, and waits for the memory's data_ready.
- Returns read data and a one-cycle ack to the granted port; flags an error if memory never responds.

Parameters:
- ADDR_W, 16, address width; matches the CPU address width.
- TIMEOUT_CYCLES, 16, max cycles in ISSUE without mem_data_ready before abort; legal range 2..255.

Ports:
- clk  input  1  system clock; same clock as the memory model.
- reset  input  1  synchronous, active-high reset.
- p0_req / p1_req  input  1  request; hold high until the matching ack.
- p0_addr / p1_addr  input  ADDR_W  byte address.
- p0_sz / p1_sz  input  1  access size: 0 = 8-bit, 1 = 16-bit (same encoding as the CPU data-access-size constant).
- p0_we / p1_we  input  1  1 = write, 0 = read.
- p0_wdata_8 / p1_wdata_8  input  8  write data for 8-bit accesses.
- p0_wdata_16 / p1_wdata_16  input  16  write data for 16-bit accesses.
- p0_ack / p1_ack  output  1  one-cycle completion pulse.
- p0_rdata_8 / p1_rdata_8  output  8  read result; held until that port's next read completes.
- p0_rdata_16 / p1_rdata_16  output  16  read result; held until that port's next read completes.
- err  output  1  one-cycle pulse on timeout abort.
- mem_req  output  1  to memory req_rdwr.
- mem_addr  output  ADDR_W  to memory addr_in.
- mem_sz  output  1  to memory data_acc_sz.
- mem_we_8  output  1  to memory write_data_we_8; equals we when sz = 0, else 0.
- mem_we_16  output  1  to memory write_data_we_16; equals we when sz = 1, else 0.
- mem_wdata_8  output  8  to memory write_data_in_8.
- mem_wdata_16  output  16  to memory write_data_in_16.
- mem_rdata_8  input  8  from memory read_data_out_8.
- mem_rdata_16  input  16  from memory read_data_out_16.
- mem_data_ready  input  1  from memory data_ready.

Behaviour:
- All outputs are registered. Reset clears every output, state, and timeout counter to 0 and sets last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any req is high, grant it. When both are high, grant the port != last_grant (round robin).
  - Latch the granted port's addr, sz, we, and wdata into the mem_* registers; set mem_req = 1; update last_grant; clear the counter.
  - Go to ISSUE.
- ISSUE:
  - mem_req stays high and all mem_* fields are stable.
  - On an edge where mem_data_ready = 1:
    - For reads, capture mem_rdata_8 into the granted port's rdata_8 when sz = 0, else mem_rdata_16 into rdata_16.
    - Set mem_req = 0, mem_we_8 = 0, mem_we_16 = 0; assert the granted ack; go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without mem_data_ready:
    - Set mem_req = 0; pulse err for one cycle; go to DONE with no ack and no rdata update.
- DONE:
  - Ack (or err) is high for exactly this cycle; mem_req = 0. Next state is IDLE unconditionally.
  - This state is the mandatory idle gap that lets the memory's data_ready fall before any new request.
- Latency from req high at edge E to ack high: 3 cycles when the memory's internal phase is favourable, 4 otherwise. A new grant is never earlier than 1 cycle after ack.
- Requests are latched at grant. Dropping req, or changing a port's inputs, before ack does not affect the in-flight access; the ack still pulses.
- The non-granted port's req is ignored until the arbiter returns to IDLE; no request is lost while held.
- A 16-bit access at address 0xFFFF is passed through unchanged; wrap behaviour belongs to the memory.
- Reset mid-ISSUE: mem_req drops on the same edge, no ack or err is issued, and rdata outputs are cleared.

Test Plan:
- Memory preloaded mem[0x0010] = 0xA5; port 0 8-bit read 0x0010 -> p0_ack within 3–4 cycles, p0_rdata_8 = 0xA5, mem_we_8 = mem_we_16 = 0 throughout.
- Port 1 16-bit write 0xBEEF to 0x0200, then port 1 16-bit read 0x0200 -> second ack returns p1_rdata_16 equal to the memory's pair ordering of 0xBEEF; exactly one write is displayed by the memory model.
- Both ports request continuously from reset -> grants alternate 0,1,0,1 over 8 transactions; every ack is separated by at least one DONE gap cycle.
- mem_data_ready tied 0 with TIMEOUT_CYCLES = 16 -> err pulses once 16 cycles after entering ISSUE; no ack; arbiter returns to IDLE and grants the next request.
- Reset asserted 1 cycle into ISSUE -> next cycle mem_req = 0, all acks = 0, rdata = 0; a subsequent port 0 read completes normally.
- Port 0 drops req 1 cycle after grant -> access still completes with p0_ack; port 1 (held high) is granted next.
